// File: rtl/alu_cmd_issuer_if.sv
// Sequencer-side instruction/result ports and ALU-side start/done ports of alu_cmd_issuer.
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic [OP_W-1:0]       in_op;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [OP_W-1:0]       alu_op;
  logic                  alu_start;
  logic                  alu_done;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_data;
  logic [OP_W-1:0]       res_op;
  logic                  res_err;
  logic [CNT_W-1:0]      fifo_count;
  logic                  busy;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_done, alu_result, res_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_start, res_valid, res_data,
           res_op, res_err, fifo_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_done, alu_result, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_start, res_valid, res_data,
           res_op, res_err, fifo_count, busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Instruction FIFO feeding a one-at-a-time ALU start/done issuer with timeout/illegal-op results.
// state | meaning: IDLE pop head | ISSUE first start cycle | WAIT start held for done | RESP result offered
module alu_cmd_issuer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_cmd_issuer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 2*DATA_W + OP_W;
  localparam int RES_W = 2*DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              start_q, start_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [OP_W-1:0]   res_op_q, res_op_d;
  logic              res_err_q, res_err_d;

  logic              in_ready;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [OP_W-1:0]   head_op;
  logic              head_legal;

  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign push       = bus.in_valid & in_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_op    = head[OP_W-1:0];
  assign head_legal = (head_op == OP_W'(1)) || (head_op == OP_W'(2)) ||
                      (head_op == OP_W'(3)) || (head_op == OP_W'(4));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    start_d     = start_q;
    tmo_d       = tmo_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_a, bus.in_b, bus.in_op};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          a_d  = head[ENT_W-1 -: DATA_W];
          b_d  = head[OP_W +: DATA_W];
          op_d = head_op;
          if (head_legal) begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end else if (head_op != '0) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_op_d    = head_op;
            res_err_d   = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a timeout expiring on the same edge
        if (bus.alu_done) begin
          start_d     = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = bus.alu_result;
          res_op_d    = op_q;
          res_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          start_d     = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_op_d    = op_q;
          res_err_d   = 1'b1;
          state_d     = S_RESP;
        end else if (tmo_q != TMO_W'(TIMEOUT)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      start_q     <= 1'b0;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      start_q     <= start_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_start  = start_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_op     = res_op_q;
  assign bus.res_err    = res_err_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
endmodule
